// File: rtl/shift_sequencer_if.sv
// Request/response bundle between the ALU controller and shift_sequencer.
// Handshake: an op is taken on a rising edge where start=1 and ready=1; done is a one-cycle pulse with R valid.
interface shiftSequencerIf;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        ready;
  logic        done;
  logic [31:0] R;

  modport master (
    output start, op, A, B,
    input  ready, done, R
  );

  modport slave (
    input  start, op, A, B,
    output ready, done, R
  );
endinterface

// File: rtl/shift_sequencer.sv
// Multi-cycle SLL/SRL/SRA/ROR unit that walks the 1/2/4/8/16 log-shift stages one per cycle.
// Optional SHIFT_EARLY_EXIT_EN ends the walk once no higher shamt bit is set.
module shift_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
  shiftSequencerIf.slave  bus,
  output logic [1:0]      stateDbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } stateT;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  stateT            stateQ;
  stateT            stateNext;
  logic [WIDTH-1:0] workQ;
  logic [WIDTH-1:0] rQ;
  logic [1:0]       opQ;
  logic [4:0]       shamtQ;
  logic             ovfQ;
  logic             signQ;
  logic [2:0]       kQ;

  logic             accept;
  logic             lastStage;
  logic [4:0]       stepAmt;
  logic [5:0]       rotLeftAmt;
  logic [7:0]       shamtPad;
  logic [WIDTH-1:0] fillMask;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] forcedVal;
  logic             forceOvf;
  logic [WIDTH-1:0] stageOut;

  // A new op is taken in IDLE and also in DONE, which gives back-to-back issue.
  assign accept = bus.start && (stateQ != SHIFT);

  always_comb begin
    stepAmt    = 5'd1 << kQ;
    rotLeftAmt = 6'd32 - {1'b0, stepAmt};
    shamtPad   = {3'b000, shamtQ};
    fillMask   = ~({WIDTH{1'b1}} >> stepAmt);
    forceOvf   = ovfQ && (opQ != OP_ROR);
    forcedVal  = {WIDTH{signQ && (opQ == OP_SRA)}};
    shifted    = workQ;
    case (opQ)
      OP_SLL:  shifted = workQ << stepAmt;
      OP_SRL:  shifted = workQ >> stepAmt;
      OP_SRA:  shifted = (workQ >> stepAmt) | (fillMask & {WIDTH{signQ}});
      OP_ROR:  shifted = (workQ >> stepAmt) | (workQ << rotLeftAmt);
      default: shifted = workQ;
    endcase
    // An out-of-range non-rotate amount saturates regardless of the stage being walked.
    if (forceOvf) begin
      stageOut = forcedVal;
    end else if (shamtPad[kQ]) begin
      stageOut = shifted;
    end else begin
      stageOut = workQ;
    end
  end

  always_comb begin
`ifdef SHIFT_EARLY_EXIT_EN
    lastStage = (kQ == 3'd4) || ((shamtQ >> (kQ + 3'd1)) == 5'd0) || forceOvf;
`else
    lastStage = (kQ == 3'd4);
`endif
  end

  always_comb begin
    stateNext = stateQ;
    case (stateQ)
      IDLE:    if (accept) stateNext = SHIFT;
      SHIFT:   if (lastStage) stateNext = DONE;
      DONE:    stateNext = accept ? SHIFT : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateNext;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      workQ  <= '0;
      rQ     <= '0;
      opQ    <= OP_SLL;
      shamtQ <= 5'd0;
      ovfQ   <= 1'b0;
      signQ  <= 1'b0;
      kQ     <= 3'd0;
    end else if (accept) begin
      workQ  <= bus.A;
      opQ    <= bus.op;
      shamtQ <= bus.B[4:0];
      ovfQ   <= |bus.B[31:5];
      signQ  <= bus.A[WIDTH-1];
      kQ     <= 3'd0;
    end else if (stateQ == SHIFT) begin
      workQ <= stageOut;
      kQ    <= kQ + 3'd1;
      if (lastStage) begin
        rQ <= stageOut;
      end
    end
  end

  assign bus.ready = (stateQ != SHIFT);
  assign bus.done  = (stateQ == DONE);
  assign bus.R     = rQ;
  assign stateDbg  = stateQ;

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer: driver pushes expected result and done cycle, monitor checks each done.
module tb_shift_sequencer;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] stateDbg;

  shiftSequencerIf bus();

  shift_sequencer #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .stateDbg (stateDbg)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  logic [31:0] exp_q[$];
  int          expCycle_q[$];
  int          checks = 0;
  int          errors = 0;

  function automatic int expLat(input logic [1:0] op, input logic [31:0] b);
    int lat;
    lat = 5;
`ifdef SHIFT_EARLY_EXIT_EN
    if ((|b[31:5]) && (op != ROR)) begin
      lat = 1;
    end else begin
      lat = 1;
      for (int i = 0; i < 5; i++) if (b[i]) lat = i + 1;
    end
`else
    if (op == 2'b00 && b == 32'hFFFF_FFFF) lat = 5;
`endif
    return lat;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expR, input bit track, output int acceptCycle);
    int waited;
    waited = 0;
    acceptCycle = -1;
    @(negedge clk);
    while (!bus.ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: ready still %b after %0d cycles", bus.ready, waited);
      return;
    end
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk);
    #1;
    acceptCycle = cycle;
    bus.start   = 1'b0;
    if (track) begin
      exp_q.push_back(expR);
      expCycle_q.push_back(cycle + expLat(op, b));
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL missing_done: expected R=%h at cycle %0d, got no done", exp_q[0], expCycle_q[0]);
      void'(exp_q.pop_front());
      void'(expCycle_q.pop_front());
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation in value and cycle.
  always @(negedge clk) begin
    logic [31:0] e;
    int          c;
    if (!rst && bus.done) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: R=%h at cycle %0d, required no done", bus.R, cycle);
      end else begin
        e = exp_q.pop_front();
        c = expCycle_q.pop_front();
        if (bus.R !== e || cycle != c || bus.ready !== 1'b1) begin
          errors++;
          $display("FAIL result: R=%h cycle %0d ready %b, expected R=%h cycle %0d ready 1",
                   bus.R, cycle, bus.ready, e, c);
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vecT;

  vecT vecs[10];

  initial begin
    int n, n1, n2;

    vecs[0] = '{SRA, 32'h8000_0010, 32'h0000_0004, 32'hF800_0001};
    vecs[1] = '{SRL, 32'h8000_0010, 32'h0000_0004, 32'h0800_0001};
    vecs[2] = '{SLL, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000};
    vecs[3] = '{SRA, 32'h8000_0000, 32'h0000_0020, 32'hFFFF_FFFF};
    vecs[4] = '{SRL, 32'hFFFF_FFFF, 32'h0000_0020, 32'h0000_0000};
    vecs[5] = '{SLL, 32'hFFFF_FFFF, 32'h0000_0020, 32'h0000_0000};
    vecs[6] = '{ROR, 32'h0000_0001, 32'h0000_0021, 32'h8000_0000};
    vecs[7] = '{ROR, 32'h1234_5678, 32'h0000_0008, 32'h7812_3456};
    vecs[8] = '{SRA, 32'h89AB_CDEF, 32'h0000_0000, 32'h89AB_CDEF};
    vecs[9] = '{SRA, 32'h7FFF_FFF0, 32'h0000_0011, 32'h0000_3FFF};

    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = '0;
    bus.B     = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ready", {31'b0, bus.ready}, 32'd1);
    check("reset_done",  {31'b0, bus.done},  32'd0);
    check("reset_R",     bus.R,              32'h0000_0000);
    check("reset_state", {30'b0, stateDbg},  32'd0);

    // Directed table; odd entries get an idle gap so both IDLE and DONE accept paths are used.
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, 1'b1, n);
      if (i % 2 == 1) begin
        drain();
        repeat (2) @(negedge clk);
      end
    end
    drain();

    // Overflow ROR with shamt=0 passes A through.
    issue(ROR, 32'hDEAD_BEEF, 32'h0000_0040, 32'hDEAD_BEEF, 1'b1, n);
    drain();

    // start during SHIFT with different operands must be ignored.
    issue(SRL, 32'hF000_0000, 32'h0000_0004, 32'h0F00_0000, 1'b1, n);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = SLL;
    bus.A     = 32'h1234_5678;
    bus.B     = 32'h0000_0001;
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain();
    repeat (2) @(negedge clk);
    check("r_hold", bus.R, 32'h0F00_0000);

    // Back-to-back: second start held into the DONE cycle.
    issue(SRA, 32'h8000_0010, 32'h0000_0004, 32'hF800_0001, 1'b1, n1);
    issue(SRL, 32'h8000_0010, 32'h0000_0004, 32'h0800_0001, 1'b1, n2);
    check("b2b_interval", n2 - n1, expLat(SRA, 32'h0000_0004) + 1);
    drain();

    // Reset during stage 2 aborts the op without a done pulse.
    issue(SRA, 32'h8000_0010, 32'h0000_001F, 32'h0, 1'b0, n);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, bus.ready}, 32'd1);
    check("abort_done",  {31'b0, bus.done},  32'd0);
    check("abort_R",     bus.R,              32'h0000_0000);
    check("abort_state", {30'b0, stateDbg},  32'd0);
    repeat (8) @(negedge clk);
    check("abort_R_after", bus.R, 32'h0000_0000);

    issue(ROR, 32'h1234_5678, 32'h0000_0008, 32'h7812_3456, 1'b1, n);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
